// File: rtl/lsnn_if.sv
// Handshake and data bundle for the time-multiplexed LSNN neuron array.
// The controller side uses the master modport and the array uses the slave modport.
interface lsnn_if #(
  parameter int N_CH = 4,
  parameter int W    = 8
);
  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              step;
  logic [N_CH*W-1:0] cur_in;
  logic [SW-1:0]     mon_sel;
  logic [N_CH-1:0]   spike_out;
  logic              done;
  logic              busy;
  logic              overrun;
  logic [W-1:0]      thr_mon;

  modport master (
    output step, cur_in, mon_sel,
    input  spike_out, done, busy, overrun, thr_mon
  );

  modport slave (
    input  step, cur_in, mon_sel,
    output spike_out, done, busy, overrun, thr_mon
  );
endinterface

// File: rtl/lsnn_array.sv
// Time-multiplexed adaptive LIF (LSNN) neuron array, one channel updated per cycle.
// The optional refractory period is enabled by defining LSNN_REFRAC_EN.
//
// state | meaning
// IDLE  | waiting for step; the input currents are snapshotted on acceptance
// RUN   | updating channel ch_q; advances to DONE after the last channel
// DONE  | publishes the spike buffer to spike_out and pulses done
module lsnn_array #(
  parameter int N_CH        = 4,
  parameter int W           = 8,
  parameter int B0          = 8,
  parameter int A0          = 8,
  parameter int LEAK_SHIFT  = 1,
  parameter int ADAPT_SHIFT = 2,
  parameter int REFRAC      = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  lsnn_if.slave bus
);

  localparam int CW = $clog2(N_CH);
  localparam logic [W-1:0]  MAX_V = {W{1'b1}};
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Sums are formed two bits wider than the datapath, then clamped.
  function automatic logic [W-1:0] sat(input logic [W+1:0] s);
    return (s > {2'b00, MAX_V}) ? MAX_V : s[W-1:0];
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [N_CH*W-1:0] cur_snap_q;
  logic [N_CH-1:0]   spk_buf_q;
  logic [N_CH-1:0]   spike_out_q;
  logic              done_q;
  logic              overrun_q, overrun_d;
  logic              snap_en;
  logic              load_out;

  logic [W-1:0] v_q [N_CH];
  logic [W-1:0] a_q [N_CH];

  logic [W-1:0] cur_c, v_c, a_c, thr_c, vn_c, a_up_c, a_dn_c;
  logic         spike_c;
  logic         refr_c;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    snap_en   = 1'b0;
    load_out  = 1'b0;
    overrun_d = overrun_q | (bus.step && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (bus.step) begin
          state_d = RUN;
          ch_d    = '0;
          snap_en = 1'b1;
        end
      end
      RUN: begin
        if (ch_q == LAST_CH) state_d = DONE;
        else                 ch_d    = ch_q + 1'b1;
      end
      DONE: begin
        state_d  = IDLE;
        load_out = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cur_snap_q  <= '0;
      spike_out_q <= '0;
      done_q      <= 1'b0;
    end else begin
      if (snap_en) cur_snap_q <= bus.cur_in;
      if (load_out) spike_out_q <= spk_buf_q;
      done_q <= load_out;
    end
  end

`ifdef LSNN_REFRAC_EN
  localparam int RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);

  logic [RW-1:0] rc_q [N_CH];

  assign refr_c = (rc_q[ch_q] != '0);

  // Per-channel refractory down-counter, reloaded on every spike.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int c = 0; c < N_CH; c++) rc_q[c] <= '0;
    end else if (state_q == RUN) begin
      if (spike_c)     rc_q[ch_q] <= RW'(REFRAC);
      else if (refr_c) rc_q[ch_q] <= rc_q[ch_q] - 1'b1;
    end
  end
`else
  assign refr_c = 1'b0;
`endif

  always_comb begin
    cur_c  = cur_snap_q[ch_q*W +: W];
    v_c    = v_q[ch_q];
    a_c    = a_q[ch_q];
    thr_c  = sat((W+2)'(B0) + {2'b00, a_c});
    vn_c   = refr_c ? (v_c >> LEAK_SHIFT)
                    : sat({2'b00, cur_c} + {2'b00, v_c >> LEAK_SHIFT});
    spike_c = !refr_c && (vn_c >= thr_c);
    a_up_c = sat({2'b00, a_c} + {2'b00, a_c >> ADAPT_SHIFT} + (W+2)'(1));
    a_dn_c = a_c - (a_c >> ADAPT_SHIFT);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        v_q[c] <= '0;
        a_q[c] <= W'(A0);
      end
      spk_buf_q <= '0;
    end else if (state_q == RUN) begin
      v_q[ch_q]       <= spike_c ? '0 : vn_c;
      a_q[ch_q]       <= spike_c ? a_up_c : a_dn_c;
      spk_buf_q[ch_q] <= spike_c;
    end
  end

  logic [W-1:0] mon_a;

  always_comb begin
    mon_a = W'(A0);
    if (32'(bus.mon_sel) < N_CH) mon_a = a_q[bus.mon_sel];
  end

  assign bus.thr_mon   = sat((W+2)'(B0) + {2'b00, mon_a});
  assign bus.spike_out = spike_out_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_lsnn_array.sv
// Directed self-checking bench for lsnn_array at default parameters.
// Expected values are hand-computed from the neuron update equations.
module tb_lsnn_array;
  localparam int N_CH = 4;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [N_CH-1:0] sp;
  logic seen_done;

  lsnn_if #(.N_CH(N_CH), .W(W)) bus ();

  lsnn_array #(.N_CH(N_CH), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mon(input int c, input logic [W-1:0] exp, input string tag);
    bus.mon_sel = 2'(c);
    #1;
    chk(tag, 32'(bus.thr_mon), 32'(exp));
  endtask

  // One full step: accept at edge 0, done after edge N_CH+1, one-cycle pulse.
  task automatic run_step(input logic [N_CH*W-1:0] cur, output logic [N_CH-1:0] spk);
    bus.cur_in = cur;
    bus.step   = 1'b1;
    tick();
    bus.step   = 1'b0;
    bus.cur_in = '0;
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    repeat (N_CH) tick();
    chk("done_not_early", 32'(bus.done), 32'd0);
    tick();
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("busy_clear", 32'(bus.busy), 32'd0);
    spk = bus.spike_out;
    tick();
    chk("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  initial begin
    bus.step    = 1'b0;
    bus.cur_in  = '0;
    bus.mon_sel = '0;
    rst_n       = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();

    chk("rst_spike_out", 32'(bus.spike_out), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    mon(0, 8'd16, "rst_thr_ch0");
    mon(3, 8'd16, "rst_thr_ch3");

    // Step 1 written out to observe per-channel write timing of thr_mon.
    bus.cur_in = {8'd0, 8'd0, 8'd10, 8'd20};
    bus.step   = 1'b1;
    tick();
    bus.step   = 1'b0;
    bus.cur_in = '0;
    tick();
    mon(0, 8'd19, "s1_thr_ch0_after_edge1");
    mon(1, 8'd16, "s1_thr_ch1_not_yet");
    repeat (3) tick();
    chk("s1_done_not_early", 32'(bus.done), 32'd0);
    tick();
    chk("s1_done", 32'(bus.done), 32'd1);
    chk("s1_spike_out", 32'(bus.spike_out), 32'h1);
    mon(0, 8'd19, "s1_thr_ch0");
    mon(1, 8'd14, "s1_thr_ch1");
    tick();

    run_step({8'd0, 8'd0, 8'd10, 8'd0}, sp);
    chk("s2_spike_out", 32'(sp), 32'h2);
    mon(0, 8'd17, "s2_thr_ch0");
    mon(1, 8'd16, "s2_thr_ch1");
    mon(2, 8'd13, "s2_thr_ch2");

    // Refractory behaviour from a fresh reset, cur0=20 every step.
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    run_step({8'd0, 8'd0, 8'd0, 8'd20}, sp);
    chk("rf_s1_bit0", 32'(sp[0]), 32'd1);
    run_step({8'd0, 8'd0, 8'd0, 8'd20}, sp);
`ifdef LSNN_REFRAC_EN
    chk("rf_s2_bit0", 32'(sp[0]), 32'd0);
    run_step({8'd0, 8'd0, 8'd0, 8'd20}, sp);
    chk("rf_s3_bit0", 32'(sp[0]), 32'd0);
    mon(0, 8'd15, "rf_thr_before_s4");
    run_step({8'd0, 8'd0, 8'd0, 8'd20}, sp);
    chk("rf_s4_bit0", 32'(sp[0]), 32'd1);
`else
    chk("nrf_s2_bit0", 32'(sp[0]), 32'd1);
    mon(0, 8'd22, "nrf_thr_after_s2");
    run_step({8'd0, 8'd0, 8'd0, 8'd20}, sp);
    chk("nrf_s3_bit0", 32'(sp[0]), 32'd0);
    run_step({8'd0, 8'd0, 8'd0, 8'd20}, sp);
    chk("nrf_s4_bit0", 32'(sp[0]), 32'd1);
`endif

    // step re-asserted mid-RUN: ignored, sets sticky overrun.
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    tick();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    chk("ovr_busy", 32'(bus.busy), 32'd1);
    repeat (2) tick();
    chk("ovr_done_not_early", 32'(bus.done), 32'd0);
    tick();
    chk("ovr_done_edge5", 32'(bus.done), 32'd1);
    tick();
    chk("ovr_no_retrigger", 32'(bus.busy), 32'd0);
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);

    // Full-scale current: adaptation saturates, spikes persist.
    for (int i = 0; i < 25; i++) begin
      run_step({N_CH{8'd255}}, sp);
      chk("sat_spikes", 32'(sp), 32'hF);
    end
    for (int c = 0; c < N_CH; c++) mon(c, 8'd255, "sat_thr");
    chk("sat_overrun_kept", 32'(bus.overrun), 32'd1);

    // Reset in the middle of RUN aborts the step with no done.
    bus.cur_in = {N_CH{8'd255}};
    bus.step   = 1'b1;
    tick();
    bus.step   = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    #2;
    chk("mrst_spike_out", 32'(bus.spike_out), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_overrun", 32'(bus.overrun), 32'd0);
    mon(0, 8'd16, "mrst_thr_ch0");
    mon(3, 8'd16, "mrst_thr_ch3");
    tick();
    rst_n = 1'b0;
    seen_done = 1'b0;
    repeat (8) begin
      tick();
      if (bus.done) seen_done = 1'b1;
    end
    chk("mrst_no_done", 32'(seen_done), 32'd0);
    chk("mrst_idle", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
